// File: rtl/processor_pkg.sv
// Processor-wide constants and interrupt sequencer state encoding.
// The decoder's RTI pop logic reuses the widths below.
package processor_pkg;

  localparam int PC_W   = 32;
  localparam int DATA_W = 16;
  localparam int CCR_W  = 3;

  localparam logic [31:0] VECTOR_ADDR = 32'h0000_0002;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_PUSH_HI  = 3'd2,
    ST_PUSH_LO  = 3'd3,
    ST_PUSH_CCR = 3'd4,
    ST_VECTOR   = 3'd5,
    ST_ISR      = 3'd6
  } int_state_e;

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector with a sticky pending flag; one-cycle latency from edge to pending.
// No backpressure: extra edges merge into the pending flag until i_clr consumes it.
module irq_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_irq,
  input  logic i_clr,
  output logic o_pending
);

  logic r_irq_q;
  logic r_pending;
  logic w_edge;

  assign w_edge    = i_irq & ~r_irq_q;
  assign o_pending = r_pending;

  // A fresh edge in the consume cycle is a new request, so set wins over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_q   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_irq_q   <= i_irq;
      r_pending <= w_edge | (r_pending & ~i_clr);
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: drain, flush, push PC (and CCR when INT_SAVE_CCR_EN), load vector.
// Best-case entry 6 cycles after the edge (5 without CCR); each mem_gnt-low cycle stalls a push.
module interrupt_sequencer #(
  parameter int                PC_W        = processor_pkg::PC_W,
  parameter int                DATA_W      = processor_pkg::DATA_W,
  parameter int                CCR_W       = processor_pkg::CCR_W,
  parameter logic [PC_W-1:0]   VECTOR_ADDR = processor_pkg::VECTOR_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              irq,
  input  logic              pipe_busy,
  input  logic [PC_W-1:0]   cur_pc,
  input  logic [CCR_W-1:0]  ccr,
  input  logic              mem_gnt,
  input  logic              rti_done,
  output logic              freeze_fetch,
  output logic              flush_pipe,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_data,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_load_addr,
  output logic              int_active
);

  import processor_pkg::*;

  int_state_e        r_state;
  int_state_e        w_state_nxt;
  logic              w_pending;
  logic              w_consume;
  logic [PC_W-1:0]   r_saved_pc;

`ifdef INT_SAVE_CCR_EN
  logic [CCR_W-1:0]  r_saved_ccr;
`else
  logic              w_unused_ccr;
  assign w_unused_ccr = ^ccr;
`endif

  assign w_consume    = (r_state == ST_DRAIN) && !pipe_busy;
  assign pc_load_addr = VECTOR_ADDR;

  irq_edge_detect u_irq_edge_detect (
    .clk       (clk),
    .rst       (rst),
    .i_irq     (irq),
    .i_clr     (w_consume),
    .o_pending (w_pending)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Return context is sampled in the same cycle the pipeline is flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_saved_pc  <= '0;
`ifdef INT_SAVE_CCR_EN
      r_saved_ccr <= '0;
`endif
    end else if (w_consume) begin
      r_saved_pc  <= cur_pc;
`ifdef INT_SAVE_CCR_EN
      r_saved_ccr <= ccr;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    freeze_fetch = 1'b0;
    flush_pipe   = 1'b0;
    mem_req      = 1'b0;
    mem_data     = '0;
    pc_load      = 1'b0;
    int_active   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pending) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        freeze_fetch = 1'b1;
        if (!pipe_busy) begin
          flush_pipe  = 1'b1;
          w_state_nxt = ST_PUSH_HI;
        end
      end
      ST_PUSH_HI: begin
        freeze_fetch = 1'b1;
        mem_req      = 1'b1;
        mem_data     = r_saved_pc[PC_W-1 -: DATA_W];
        if (mem_gnt) w_state_nxt = ST_PUSH_LO;
      end
      ST_PUSH_LO: begin
        freeze_fetch = 1'b1;
        mem_req      = 1'b1;
        mem_data     = r_saved_pc[DATA_W-1:0];
`ifdef INT_SAVE_CCR_EN
        if (mem_gnt) w_state_nxt = ST_PUSH_CCR;
`else
        if (mem_gnt) w_state_nxt = ST_VECTOR;
`endif
      end
`ifdef INT_SAVE_CCR_EN
      ST_PUSH_CCR: begin
        freeze_fetch = 1'b1;
        mem_req      = 1'b1;
        mem_data     = {{(DATA_W-CCR_W){1'b0}}, r_saved_ccr};
        if (mem_gnt) w_state_nxt = ST_VECTOR;
      end
`endif
      ST_VECTOR: begin
        freeze_fetch = 1'b1;
        pc_load      = 1'b1;
        w_state_nxt  = ST_ISR;
      end
      ST_ISR: begin
        int_active = 1'b1;
        if (rti_done) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer; expectations adapt to INT_SAVE_CCR_EN.
module tb_interrupt_sequencer;

`ifdef INT_SAVE_CCR_EN
  localparam int NPUSH = 3;
`else
  localparam int NPUSH = 2;
`endif
  localparam int NLOW = NPUSH + 3;

  logic        clk;
  logic        rst;
  logic        irq;
  logic        pipe_busy;
  logic [31:0] cur_pc;
  logic [2:0]  ccr;
  logic        mem_gnt;
  logic        rti_done;
  logic        freeze_fetch;
  logic        flush_pipe;
  logic        mem_req;
  logic [15:0] mem_data;
  logic        pc_load;
  logic [31:0] pc_load_addr;
  logic        int_active;

  int n_tests = 0;
  int n_fail  = 0;
  int push_cnt = 0;

  interrupt_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .irq          (irq),
    .pipe_busy    (pipe_busy),
    .cur_pc       (cur_pc),
    .ccr          (ccr),
    .mem_gnt      (mem_gnt),
    .rti_done     (rti_done),
    .freeze_fetch (freeze_fetch),
    .flush_pipe   (flush_pipe),
    .mem_req      (mem_req),
    .mem_data     (mem_data),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .int_active   (int_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfers are counted just before the rising edge that completes them.
  always @(negedge clk) begin
    #3;
    if (mem_req && mem_gnt) push_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int base;
    int low;
    logic done;

    rst = 1'b1; irq = 1'b0; pipe_busy = 1'b0; cur_pc = '0; ccr = '0;
    mem_gnt = 1'b0; rti_done = 1'b0;
    repeat (2) tick();
    #1;
    check("rst_ctrl", {27'd0, freeze_fetch, flush_pipe, mem_req, pc_load, int_active}, 32'd0);
    check("rst_data", {16'd0, mem_data}, 32'd0);
    check("rst_addr", pc_load_addr, 32'h0000_0002);
    tick(); rst = 1'b0;

    // Best case entry
    tick(); cur_pc = 32'h0001_2345; ccr = 3'b101; mem_gnt = 1'b1; irq = 1'b1; base = push_cnt;
    tick(); #1 check("t1_k_idle", {31'd0, freeze_fetch}, 32'd0);
    tick(); #1 check("t1_drain", {30'd0, freeze_fetch, flush_pipe}, 32'd3);
    tick(); #1 check("t1_hi", {15'd0, mem_req, mem_data}, {15'd0, 1'b1, 16'h0001});
    tick(); #1 check("t1_lo", {15'd0, mem_req, mem_data}, {15'd0, 1'b1, 16'h2345});
`ifdef INT_SAVE_CCR_EN
    tick(); #1 check("t1_ccr", {15'd0, mem_req, mem_data}, {15'd0, 1'b1, 16'h0005});
`endif
    tick(); #1;
    check("t1_vec", {29'd0, pc_load, freeze_fetch, mem_req}, 32'd6);
    check("t1_vec_addr", pc_load_addr, 32'h0000_0002);
    tick(); #1;
    check("t1_isr", {29'd0, int_active, pc_load, freeze_fetch}, 32'd4);
    check("t1_pushes", push_cnt - base, NPUSH);

    // Held irq must not re-request; rti_done outside ISR is ignored
    tick(); rti_done = 1'b1;
    tick(); rti_done = 1'b0; #1 check("t1_rti_idle", {31'd0, int_active}, 32'd0);
    repeat (3) tick();
    #1 check("t1_held_single", {30'd0, freeze_fetch, int_active}, 32'd0);
    tick(); rti_done = 1'b1;
    tick(); rti_done = 1'b0; #1 check("t1_rti_ignored", {30'd0, freeze_fetch, int_active}, 32'd0);

    // pipe_busy stall then mem_gnt stall in PUSH_LO
    tick(); irq = 1'b0;
    tick(); pipe_busy = 1'b1; cur_pc = 32'hDEAD_BEEF; ccr = 3'b111; irq = 1'b1; base = push_cnt;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick(); #1 check("t2_drain_busy", {30'd0, freeze_fetch, flush_pipe}, 32'd2);
    end
    tick(); pipe_busy = 1'b0; cur_pc = 32'h1234_ABCD; ccr = 3'b010;
    #1 check("t2_flush", {30'd0, freeze_fetch, flush_pipe}, 32'd3);
    tick(); cur_pc = 32'h5555_6666; ccr = 3'b001;
    #1 check("t2_hi", {15'd0, mem_req, mem_data}, {15'd0, 1'b1, 16'h1234});
    tick(); mem_gnt = 1'b0; #1 check("t3_lo_0", {15'd0, mem_req, mem_data}, {15'd0, 1'b1, 16'hABCD});
    tick(); #1 check("t3_lo_1", {15'd0, mem_req, mem_data}, {15'd0, 1'b1, 16'hABCD});
    tick(); mem_gnt = 1'b1; #1 check("t3_lo_2", {15'd0, mem_req, mem_data}, {15'd0, 1'b1, 16'hABCD});
`ifdef INT_SAVE_CCR_EN
    tick(); #1 check("t2_ccr", {15'd0, mem_req, mem_data}, {15'd0, 1'b1, 16'h0002});
`endif
    tick(); #1 check("t2_vec", {31'd0, pc_load}, 32'd1);
    tick(); #1;
    check("t2_isr", {31'd0, int_active}, 32'd1);
    check("t3_pushes", push_cnt - base, NPUSH);

    // Second edge during ISR, then rti_done: one IDLE cycle then re-entry
    tick(); irq = 1'b0;
    tick(); irq = 1'b1;
    tick(); #1 check("t4_no_nest", {30'd0, int_active, freeze_fetch}, 32'd2);
    base = push_cnt; rti_done = 1'b1;
    tick(); rti_done = 1'b0; #1 check("t4_idle", {30'd0, int_active, freeze_fetch}, 32'd0);
    low = 1; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick(); #1;
      if (int_active) done = 1'b1;
      else low++;
    end
    check("t4_reentry_done", {31'd0, done}, 32'd1);
    check("t4_low_cycles", low, NLOW);
    check("t4_pushes", push_cnt - base, NPUSH);

    // Reset in PUSH_LO aborts asynchronously
    tick(); irq = 1'b0; rti_done = 1'b1;
    tick(); rti_done = 1'b0;
    tick(); irq = 1'b1;
    repeat (4) tick();
    #1 check("t5_in_lo", {15'd0, mem_req, mem_data}, {15'd0, 1'b1, 16'h6666});
    rst = 1'b1; irq = 1'b0;
    #1;
    check("t5_rst_ctrl", {27'd0, freeze_fetch, flush_pipe, mem_req, pc_load, int_active}, 32'd0);
    check("t5_rst_data", {16'd0, mem_data}, 32'd0);
    tick(); rst = 1'b0;
    repeat (3) tick();
    #1 check("t5_stay_idle", {29'd0, freeze_fetch, mem_req, int_active}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
